// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready flow control.
// The bit-level generate/propagate terms pass through $clog2(N) black-cell
// levels, then a grey-cell stage folds in the carry-in and forms sum and flags.
// PIPE_STAGES register ranks are spread evenly over those logic stages; the
// last rank always holds the outputs. Every rank stores one beat plus a valid
// bit and loads when it is empty or when its successor advances.
module pipelined_prefix_adder #(
  parameter int N           = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  localparam int L = $clog2(N);
  localparam int R = PIPE_STAGES;

  if (N < 2) begin : g_bad_width
    $error("pipelined_prefix_adder: N must be at least 2");
  end
  if (R < 1 || R > L + 1) begin : g_bad_stages
    $error("pipelined_prefix_adder: PIPE_STAGES must lie in 1..$clog2(N)+1");
  end

  // Logic stage s (0..L-1 = prefix levels, L = grey/sum stage) lives in this rank.
  function automatic int rank_of(input int s);
    return (s * R) / (L + 1);
  endfunction

  logic [R-1:0] valid_reg;
  logic [R-1:0] valid_in;
  logic [R-1:0] load;

  genvar gi;

  // A rank can load unless it and every rank after it are full while the sink stalls.
  for (gi = 0; gi < R; gi++) begin : g_ctl
    if (gi == 0) begin : g_first
      assign valid_in[gi] = in_valid;
    end else begin : g_next
      assign valid_in[gi] = valid_reg[gi-1];
    end
    assign load[gi] = out_ready || !(&valid_reg[R-1:gi]);
  end

  assign in_ready  = load[0];
  assign out_valid = valid_reg[R-1];

  // Rank valid bits: a loading rank takes its predecessor's valid, others hold.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= (valid_reg & ~load) | (valid_in & load);
    end
  end

  logic [N-1:0] b_eff;
  assign b_eff = in_sub ? ~in_b : in_b;

  for (gi = 0; gi < L; gi++) begin : g_lvl
    localparam int SPAN = 1 << gi;
    logic [N-1:0] g_in, p_in, pb_in;
    logic         c0_in;
    logic [N-1:0] g_out, p_out;

    if (gi == 0) begin : g_src
      assign g_in  = in_a & b_eff;
      assign p_in  = in_a ^ b_eff;
      assign pb_in = in_a ^ b_eff;
      assign c0_in = in_sub ^ in_cin;
    end else if (rank_of(gi) != rank_of(gi - 1)) begin : g_rank
      localparam int K = rank_of(gi - 1);
      logic [N-1:0] g_reg, p_reg, pb_reg;
      logic         c0_reg;
      // Rank boundary between two prefix levels.
      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
          g_reg  <= '0;
          p_reg  <= '0;
          pb_reg <= '0;
          c0_reg <= 1'b0;
        end else if (load[K] && valid_in[K]) begin
          g_reg  <= g_lvl[gi-1].g_out;
          p_reg  <= g_lvl[gi-1].p_out;
          pb_reg <= g_lvl[gi-1].pb_in;
          c0_reg <= g_lvl[gi-1].c0_in;
        end
      end
      assign g_in  = g_reg;
      assign p_in  = p_reg;
      assign pb_in = pb_reg;
      assign c0_in = c0_reg;
    end else begin : g_pass
      assign g_in  = g_lvl[gi-1].g_out;
      assign p_in  = g_lvl[gi-1].p_out;
      assign pb_in = g_lvl[gi-1].pb_in;
      assign c0_in = g_lvl[gi-1].c0_in;
    end

    // One black-cell level: combine each bit with the group SPAN positions below.
    always_comb begin
      g_out = g_in;
      p_out = p_in;
      for (int i = SPAN; i < N; i++) begin
        g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
        p_out[i] = p_in[i] & p_in[i-SPAN];
      end
    end
  end

  logic [N-1:0] fg, fp, fpb;
  logic         fc0;

  if (rank_of(L) != rank_of(L - 1)) begin : g_frank
    localparam int K = rank_of(L - 1);
    logic [N-1:0] g_reg, p_reg, pb_reg;
    logic         c0_reg;
    // Rank boundary in front of the grey-cell stage.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        g_reg  <= '0;
        p_reg  <= '0;
        pb_reg <= '0;
        c0_reg <= 1'b0;
      end else if (load[K] && valid_in[K]) begin
        g_reg  <= g_lvl[L-1].g_out;
        p_reg  <= g_lvl[L-1].p_out;
        pb_reg <= g_lvl[L-1].pb_in;
        c0_reg <= g_lvl[L-1].c0_in;
      end
    end
    assign fg  = g_reg;
    assign fp  = p_reg;
    assign fpb = pb_reg;
    assign fc0 = c0_reg;
  end else begin : g_fpass
    assign fg  = g_lvl[L-1].g_out;
    assign fp  = g_lvl[L-1].p_out;
    assign fpb = g_lvl[L-1].pb_in;
    assign fc0 = g_lvl[L-1].c0_in;
  end

  logic [N-1:0] co, carry, sum_c;

  // Grey cells: carry out of bit i includes the carry-in; carry into bit i is the one below.
  always_comb begin
    co    = fg | (fp & {N{fc0}});
    carry = {co[N-2:0], fc0};
    sum_c = fpb ^ carry;
  end

  // Output rank: holds its beat until the sink accepts it.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (load[R-1] && valid_in[R-1]) begin
      out_sum  <= sum_c;
      out_cout <= co[N-1];
      out_ovf  <= co[N-1] ^ carry[N-1];
      out_zero <= ~|sum_c;
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: directed N=8/PIPE_STAGES=2 cases, then randomized
// traffic with a toggling sink on several width/depth configurations, each
// scored against an arithmetic reference model.
module tb_pipelined_prefix_adder;

  localparam int NDUT = 6;
  localparam int NW [NDUT] = '{8, 8, 24, 24, 32, 64};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  logic [63:0] a_d [NDUT];
  logic [63:0] b_d [NDUT];
  logic        cin_d [NDUT];
  logic        sub_d [NDUT];
  logic        iv [NDUT];
  logic        ordy [NDUT];
  logic        irdy [NDUT];
  logic        ov [NDUT];
  logic        ocout [NDUT];
  logic        oovf [NDUT];
  logic        ozero [NDUT];
  logic [7:0]  s0, s1;
  logic [23:0] s2, s3;
  logic [31:0] s4;
  logic [63:0] s5;
  logic [63:0] osum [NDUT];

  always_comb begin
    osum[0] = 64'(s0);
    osum[1] = 64'(s1);
    osum[2] = 64'(s2);
    osum[3] = 64'(s3);
    osum[4] = 64'(s4);
    osum[5] = s5;
  end

  pipelined_prefix_adder #(.N(8), .PIPE_STAGES(2)) u_dut (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(a_d[0][7:0]), .in_b(b_d[0][7:0]), .in_cin(cin_d[0]), .in_sub(sub_d[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0), .out_cout(ocout[0]),
    .out_ovf(oovf[0]), .out_zero(ozero[0]));

  pipelined_prefix_adder #(.N(8), .PIPE_STAGES(4)) u_dut_8x4 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(a_d[1][7:0]), .in_b(b_d[1][7:0]), .in_cin(cin_d[1]), .in_sub(sub_d[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1), .out_cout(ocout[1]),
    .out_ovf(oovf[1]), .out_zero(ozero[1]));

  pipelined_prefix_adder #(.N(24), .PIPE_STAGES(1)) u_dut_24x1 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_a(a_d[2][23:0]), .in_b(b_d[2][23:0]), .in_cin(cin_d[2]), .in_sub(sub_d[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2), .out_cout(ocout[2]),
    .out_ovf(oovf[2]), .out_zero(ozero[2]));

  pipelined_prefix_adder #(.N(24), .PIPE_STAGES(6)) u_dut_24x6 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(iv[3]), .in_ready(irdy[3]),
    .in_a(a_d[3][23:0]), .in_b(b_d[3][23:0]), .in_cin(cin_d[3]), .in_sub(sub_d[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(s3), .out_cout(ocout[3]),
    .out_ovf(oovf[3]), .out_zero(ozero[3]));

  pipelined_prefix_adder #(.N(32), .PIPE_STAGES(6)) u_dut_32x6 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(iv[4]), .in_ready(irdy[4]),
    .in_a(a_d[4][31:0]), .in_b(b_d[4][31:0]), .in_cin(cin_d[4]), .in_sub(sub_d[4]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_sum(s4), .out_cout(ocout[4]),
    .out_ovf(oovf[4]), .out_zero(ozero[4]));

  pipelined_prefix_adder #(.N(64), .PIPE_STAGES(7)) u_dut_64x7 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(iv[5]), .in_ready(irdy[5]),
    .in_a(a_d[5]), .in_b(b_d[5]), .in_cin(cin_d[5]), .in_sub(sub_d[5]),
    .out_valid(ov[5]), .out_ready(ordy[5]), .out_sum(s5), .out_cout(ocout[5]),
    .out_ovf(oovf[5]), .out_zero(ozero[5]));

  int vectors = 0;
  int miscompares = 0;
  logic [66:0] sb [NDUT][$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int n);
    return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [66:0] pack(input logic [63:0] s, input logic c, input logic v,
                                       input logic z);
    return {z, v, c, s};
  endfunction

  function automatic logic [66:0] obs(input int k);
    return pack(osum[k], ocout[k], oovf[k], ozero[k]);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [66:0] model(input int n, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic signed [67:0] one, modv, half, ua, ub, sa, sb_v, ci, r, sr;
    logic [63:0] s;
    logic c, v;
    one  = 68'sd1;
    modv = one <<< n;
    half = one <<< (n - 1);
    ua   = $signed({4'b0, a & mask_of(n)});
    ub   = $signed({4'b0, b & mask_of(n)});
    ci   = $signed({67'b0, cin});
    sa   = (ua >= half) ? ua - modv : ua;
    sb_v = (ub >= half) ? ub - modv : ub;
    if (sub) begin
      r  = ua - ub - ci;
      sr = sa - sb_v - ci;
      c  = (r >= 0);
    end else begin
      r  = ua + ub + ci;
      sr = sa + sb_v + ci;
      c  = (r >= modv);
    end
    s = 64'(r & (modv - one));
    v = (sr >= half) || (sr < -half);
    return pack(s, c, v, s == 64'd0);
  endfunction

  function automatic logic [63:0] rnd_op(input int n);
    logic [63:0] x;
    case ($urandom_range(7))
      0:       x = 64'd0;
      1:       x = 64'hFFFF_FFFF_FFFF_FFFF;
      default: x = {$urandom, $urandom};
    endcase
    return x & mask_of(n);
  endfunction

  // One directed beat on the N=8 unit; measures latency and checks the result.
  task automatic op_lat(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input logic [66:0] exp);
    int lat;
    a_d[0]   = {56'd0, a};
    b_d[0]   = {56'd0, b};
    cin_d[0] = cin;
    sub_d[0] = sub;
    iv[0]    = 1'b1;
    ordy[0]  = 1'b1;
    #1;
    chk({tag, "_in_ready"}, irdy[0], 1);
    @(negedge clk);
    iv[0] = 1'b0;
    lat   = 1;
    while (!ov[0] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_result"}, obs(0), exp);
    $display("directed %s: latency %0d sum 0x%0h cout %0b ovf %0b zero %0b",
             tag, lat, osum[0], ocout[0], oovf[0], ozero[0]);
  endtask

  // Score one cycle on every unit: pop on output transfer, push on input transfer.
  task automatic score_cycle();
    for (int k = 0; k < NDUT; k++) begin
      if (ov[k] && ordy[k]) begin
        if (sb[k].size() == 0) begin
          chk($sformatf("spurious_out_k%0d", k), ov[k], 0);
        end else begin
          chk($sformatf("rand_k%0d_n%0d", k, NW[k]), obs(k), sb[k].pop_front());
        end
      end
      if (iv[k] && irdy[k]) begin
        sb[k].push_back(model(NW[k], a_d[k], b_d[k], cin_d[k], sub_d[k]));
      end
    end
  endtask

  initial begin
    logic [66:0] q [$];
    int sent, got, lastc;

    for (int k = 0; k < NDUT; k++) begin
      a_d[k] = '0; b_d[k] = '0; cin_d[k] = 1'b0; sub_d[k] = 1'b0;
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset_state_k%0d", k), {irdy[k], ov[k], obs(k)}, {1'b1, 1'b0, 67'd0});
    end
    $display("reset: outputs checked on %0d units", NDUT);
    reset_n = 1'b1;

    op_lat("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, pack(64'h80, 1'b0, 1'b1, 1'b0));
    op_lat("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, pack(64'hFF, 1'b0, 1'b0, 1'b0));
    op_lat("sub_05_05", 8'h05, 8'h05, 1'b0, 1'b1, pack(64'h00, 1'b1, 1'b0, 1'b1));
    op_lat("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, pack(64'h00, 1'b1, 1'b0, 1'b1));
    @(negedge clk);

    // Stall: sink blocked for five cycles while six beats are offered.
    sent = 0; got = 0; lastc = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      ordy[0]  = (c >= 5);
      iv[0]    = (sent < 6);
      a_d[0]   = rnd_op(8);
      b_d[0]   = rnd_op(8);
      cin_d[0] = 1'($urandom_range(1));
      sub_d[0] = 1'($urandom_range(1));
      #1;
      if (c == 4) begin
        chk("stall_in_ready", irdy[0], 0);
        chk("stall_accepted", sent, 2);
      end
      if (c >= 2 && c <= 4) begin
        chk("stall_hold_valid", ov[0], 1);
        chk("stall_hold_data", obs(0), q[0]);
      end
      if (ov[0] && ordy[0]) begin
        chk($sformatf("stall_beat%0d", got), obs(0), q.pop_front());
        if (got > 0) chk("stall_back_to_back", c, lastc + 1);
        $display("stall: beat %0d emitted in cycle %0d sum 0x%0h", got, c, osum[0]);
        lastc = c;
        got++;
      end
      if (iv[0] && irdy[0]) begin
        q.push_back(model(8, a_d[0], b_d[0], cin_d[0], sub_d[0]));
        sent++;
      end
      @(negedge clk);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    chk("stall_count", got, 6);

    // Reset with two beats in flight.
    repeat (2) @(negedge clk);
    a_d[0] = 64'h11; b_d[0] = 64'h22; cin_d[0] = 1'b0; sub_d[0] = 1'b0; iv[0] = 1'b1;
    repeat (2) @(negedge clk);
    iv[0]   = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_out", {ov[0], obs(0)}, {1'b0, 67'd0});
    chk("midreset_in_ready", irdy[0], 1);
    $display("reset: asserted with beats in flight, out_valid %0b", ov[0]);
    @(negedge clk);
    reset_n = 1'b1;
    op_lat("post_reset", 8'h12, 8'h34, 1'b0, 1'b0, pack(64'h46, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("post_reset_idle", ov[0], 0);

    // Random traffic on all units with a 30% stalling sink.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        iv[k]    = ($urandom_range(9) < 7);
        ordy[k]  = ($urandom_range(9) >= 3);
        a_d[k]   = rnd_op(NW[k]);
        b_d[k]   = rnd_op(NW[k]);
        cin_d[k] = 1'($urandom_range(1));
        sub_d[k] = 1'($urandom_range(1));
      end
      #1;
      score_cycle();
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      #1;
      score_cycle();
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("drain_k%0d", k), sb[k].size(), 0);
      $display("random: unit %0d (N=%0d) drained, %0d left", k, NW[k], sb[k].size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
